burst_memory: RTL

Word-organised, byte-addressed main-memory model that responds to the processor-side memory interface (clock, address, data_in, access_size, rw, enable → busy, data_out). It serves fetch and load/store traffic for the MIPS datapath and the program-loader bench: it accepts single-word or fixed-length burst transfers, auto-increments the address across a burst, and flags burst occupancy on busy. Storage is big-endian and maps a window starting at 0x80020000.

---
 rtl/burst_memory_if.sv | 23 ++
 rtl/burst_memory.sv | 96 +++++++++
 2 files changed

// File: rtl/burst_memory_if.sv
// Processor-side memory bus: request fields driven by the initiator, busy/data_out by the memory.
interface burst_memory_if #(
   parameter int unsigned data_width    = 32,
   parameter int unsigned address_width = 32
);
   logic [address_width-1:0] address;
   logic [data_width-1:0]    data_in;
   logic [1:0]               access_size;
   logic                     rw;
   logic                     enable;
   logic                     busy;
   logic [data_width-1:0]    data_out;

   modport master (
      output address, data_in, access_size, rw, enable,
      input  busy, data_out
   );

   modport slave (
      input  address, data_in, access_size, rw, enable,
      output busy, data_out
   );
endinterface

// File: rtl/burst_memory.sv
// Big-endian, word-organised main memory with fixed-length bursts and a per-beat range check.
module burst_memory #(
   parameter int unsigned              data_width    = 32,
   parameter int unsigned              address_width = 32,
   parameter int unsigned              depth         = 1048576,
   parameter logic [address_width-1:0] start_addr    = 32'h80020000
) (
   input logic           clock,
   input logic           reset_n,
   burst_memory_if.slave bus
);
   localparam int unsigned words  = depth / 4;
   localparam int unsigned byte_w = $clog2(depth);

   localparam logic [1:0] st_idle   = 2'd0;
   localparam logic [1:0] st_wburst = 2'd1;
   localparam logic [1:0] st_rburst = 2'd2;

   logic [data_width-1:0]    mem [words];

   logic [1:0]               state_q;
   logic [3:0]               cnt_q;
   logic [address_width-1:0] addr_q;
   logic                     busy_q;
   logic [data_width-1:0]    data_out_q;

   logic                     idle;
   logic                     beat_en;
   logic                     beat_rd;
   logic [address_width-1:0] beat_addr;
   logic [address_width-1:0] offset;
   logic [byte_w-3:0]        idx;
   logic                     in_range;
   logic [3:0]               len_m1;
   logic                     unused_bits;

   always_comb begin
      idle      = (state_q == st_idle);
      beat_addr = idle ? {bus.address[address_width-1:2], 2'b00} : addr_q + 4;
      beat_en   = idle ? bus.enable : 1'b1;
      beat_rd   = idle ? bus.rw : (state_q == st_rburst);
      offset    = beat_addr - start_addr;
      idx       = offset[byte_w-1:2];
      // Compare in one extra bit so the end-of-window sum cannot overflow.
      in_range  = ({1'b0, beat_addr} >= {1'b0, start_addr}) &&
                  ({1'b0, beat_addr} + 33'd3 < {1'b0, start_addr} + 33'(depth));
      unique case (bus.access_size)
         2'b00:   len_m1 = 4'd0;
         2'b01:   len_m1 = 4'd3;
         2'b10:   len_m1 = 4'd7;
         default: len_m1 = 4'd15;
      endcase
   end

   assign unused_bits = ^{offset[address_width-1:byte_w], offset[1:0], bus.address[1:0]};

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q    <= st_idle;
         cnt_q      <= 4'd0;
         addr_q     <= '0;
         busy_q     <= 1'b0;
         data_out_q <= '0;
      end else begin
         if (beat_en) begin
            addr_q <= beat_addr;
            if (beat_rd) begin
               data_out_q <= in_range ? mem[idx] : '0;
            end
         end
         if (idle) begin
            if (bus.enable && len_m1 != 4'd0) begin
               state_q <= bus.rw ? st_rburst : st_wburst;
               cnt_q   <= len_m1;
               busy_q  <= 1'b1;
            end
         end else begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_q <= st_idle;
               busy_q  <= 1'b0;
            end
         end
      end
   end

   // Storage has no reset; a reset edge only suppresses the write.
   always_ff @(posedge clock) begin
      if (reset_n && beat_en && !beat_rd && in_range) begin
         mem[idx] <= bus.data_in;
      end
   end

   assign bus.busy     = busy_q;
   assign bus.data_out = data_out_q;
endmodule
